muldiv: RTL

MULDIV -- requirements
Module: muldiv

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv.sv | 124 ++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// Shared processor types: word width, ALU/MDU opcode enums and MDU FSM states.
package muldiv_pkg;

   localparam int WORD_W = 8;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SLT = 3'd5,
      ALU_SLL = 3'd6,
      ALU_SRL = 3'd7
   } e_alu_op;

   typedef enum logic {
      MDU_MUL = 1'b0,
      MDU_DIV = 1'b1
   } e_mdu_op;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } e_mdu_state;

endpackage

// File: rtl/muldiv.sv
// Iterative unsigned multiply/divide unit: one bit per cycle, shift-add multiply
// and restoring divide sharing a single 2*WIDTH+1-bit accumulator.
module muldiv
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  e_mdu_op          op,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             div_zero
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   e_mdu_state       r_state;
   e_mdu_op          r_op;
   logic [WIDTH-1:0] r_b;
   logic [2*WIDTH:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ready;
   logic             r_done;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_hi;
   logic             r_zero;
   logic             r_dz;

   logic [WIDTH:0]   w_mul_sum;
   logic [2*WIDTH:0] w_mul_next;
   logic [2*WIDTH:0] w_shl;
   logic [WIDTH:0]   w_trial;
   logic [2*WIDTH:0] w_div_next;
   logic [2*WIDTH:0] w_acc_next;

   // Multiply: acc = {carry+high, multiplier}; add multiplicand on LSB, shift right.
   // Divide:   acc = {rem (WIDTH+1), quot}; shift left, trial-subtract divisor.
   always_comb begin
      w_mul_sum  = r_acc[2*WIDTH:WIDTH] + {1'b0, r_b};
      w_mul_next = r_acc[0] ? ({w_mul_sum, r_acc[WIDTH-1:0]} >> 1) : (r_acc >> 1);
      w_shl      = {r_acc[2*WIDTH-1:0], 1'b0};
      w_trial    = w_shl[2*WIDTH:WIDTH] - {1'b0, r_b};
      w_div_next = w_trial[WIDTH] ? w_shl : {w_trial, w_shl[WIDTH-1:1], 1'b1};
      w_acc_next = (r_op == MDU_MUL) ? w_mul_next : w_div_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_op    <= MDU_MUL;
         r_b     <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_ready <= 1'b1;
         r_done  <= 1'b0;
         r_lo    <= '0;
         r_hi    <= '0;
         r_zero  <= 1'b1;
         r_dz    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_op    <= op;
                  r_b     <= srcB;
                  r_acc   <= {{(WIDTH+1){1'b0}}, srcA};
                  r_cnt   <= CNT_W'(WIDTH);
                  r_ready <= 1'b0;
                  if (op == MDU_DIV && srcB == '0) begin
                     r_lo    <= '1;
                     r_hi    <= srcA;
                     r_zero  <= 1'b0;
                     r_dz    <= 1'b1;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_dz    <= 1'b0;
                     r_state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               r_acc <= w_acc_next;
               r_cnt <= r_cnt - CNT_W'(1);
               // Last iteration: the remainder always fits in WIDTH bits, so both
               // operations take their result from the same slice.
               if (r_cnt == CNT_W'(1)) begin
                  r_lo    <= w_acc_next[WIDTH-1:0];
                  r_hi    <= w_acc_next[2*WIDTH-1:WIDTH];
                  r_zero  <= ~|w_acc_next[2*WIDTH-1:0];
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign ready     = r_ready;
   assign done      = r_done;
   assign result_lo = r_lo;
   assign result_hi = r_hi;
   assign zero      = r_zero;
   assign div_zero  = r_dz;

endmodule
